cl_net_cmd_unit: RTL
====================

# cl_net_cmd_unit

Network command front end for the core. Accepts packets from the network port, buffers them in a 2-entry FIFO, and dispatches each one as a single-cycle write strobe:
- instruction memory write;
- register file write;
- data memory write;
- the PC write command (`net_PC_write_cmd_IDLE_o`) that moves the core state machine from IDLE to RUN.

Commands are gated against the current core state.

## Interface
- `FIFO_DEPTH`, 2: packet buffer entries (power of two, ≥2).
- `CNT_W`, 8: width of the drop counter.

Ports:
- `clk` in 1: clock. The block has one clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `net_packet_i` in `net_packet_s`: fields `net_op` (`net_op_e`, 3b), `net_addr` (10b), `net_reg` (6b), `net_data` (32b).
- `net_valid_i` in 1: packet present.
- `net_ready_o` out 1: FIFO can accept.
- `state_i` in `state_e`: core state (IDLE/RUN/ERR).
- `dmem_ready_i` in 1: data memory accepts the write this cycle.
- `imem_we_o` out 1, `imem_addr_o` out 10, `imem_data_o` out 32: instruction write.
- `rf_we_o` out 1, `rf_addr_o` out 6, `rf_data_o` out 32: register write.
- `dmem_we_o` out 1, `dmem_addr_o` out 10, `dmem_data_o` out 32: data write.
- `net_PC_write_cmd_IDLE_o` out 1, `net_pc_o` out 10: PC load plus start.
- `drop_count_o` out `CNT_W`: saturating count of discarded packets.

## Operation
- **Push:** a packet is pushed when `net_valid_i && net_ready_o` at the rising edge. `net_ready_o = !full && !reset`.
- **Head decode and dispatch:** the FIFO head is decoded combinationally. At most one strobe is asserted per cycle. The head pops on the edge where its action completes.
- **Per-op action** (`net_op_e`: NULL=0, INSTR=1, REG=2, PC=3, DMEM=4, others invalid):
  - NULL: pop, no strobe, no count.
  - INSTR: `imem_we_o=1` in any state except ERR; pop.
  - REG: issued only when `state_i==IDLE`. In RUN the head stalls (head-of-line blocking); pop on issue.
  - PC: issued only when `state_i==IDLE`: `net_PC_write_cmd_IDLE_o=1`, `net_pc_o=net_addr`. In RUN the head stalls.
  - DMEM: `dmem_we_o=1` held with stable address and data until `dmem_ready_i`. Pop on the edge where both are high. Not gated by state, except ERR.
  - Invalid op (5–7): pop, no strobe, `drop_count_o` += 1.
- **ERR state:** every non-NULL head is popped without a strobe and `drop_count_o` += 1, one packet per cycle.
- **Drop counter:** saturates at all-ones and never wraps.
- **Data outputs** follow the head fields when the corresponding strobe is 0. Their value is don't-care to the bench when the strobe is low.
- **Simultaneous push and pop:** allowed whenever `net_ready_o`=1; the count is unchanged.
- **Full FIFO:** `net_ready_o`=0 and the upstream packet is held. A pop that frees a slot raises ready in the next cycle; ready is registered-count based, not pop-based.
- **Reset:** FIFO empty, all strobes 0, `drop_count_o`=0, `net_ready_o`=0 while reset is high. A reset mid-DMEM-wait discards the pending write.

## Timing
- **Latency:** a packet accepted at edge N into an empty FIFO drives its strobe in cycle N+1, when it is not gated.
- **Throughput:** one packet per cycle for INSTR, REG (IDLE), PC (IDLE), NULL and drops.
- **Strobe duration:** strobes are single-cycle, except `dmem_we_o`, which stays high until the ready handshake.
- **State sampling:** the state gate samples `state_i` in the same cycle as the strobe, so a PC command issued in IDLE is seen by the state machine in that cycle.
- **FIFO storage:** registered; pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo depth; the count is one bit wider.
- **Combinational paths:** no path from `net_valid_i` to any strobe.

## Structure
- Shared package gains `net_op_e` (3b enum) and `net_packet_s` (packed: op, addr, reg, data = 51b). `state_e` is reused from the package.
- Sub-module `cl_net_fifo`: parameterised synchronous FIFO with push/pop/full/empty/head. The decode and gating logic stays in `cl_net_cmd_unit`.

## Test plan
- **Reset then INSTR:** state IDLE; push INSTR addr=0x005 data=0xDEADBEEF → `imem_we_o`=1 with those values exactly one cycle after acceptance; FIFO empty afterwards.
- **PC gated by RUN:** state RUN; push PC addr=0x010, then INSTR → nothing issued and `net_ready_o`=0 after 2 pushes. Switch to IDLE → `net_PC_write_cmd_IDLE_o`=1 with `net_pc_o`=0x010, then INSTR strobe the next cycle.
- **DMEM backpressure:** push DMEM addr=0x3FF data=0x1 with `dmem_ready_i`=0 for 3 cycles → `dmem_we_o` held 4 cycles with stable data; pop only on the ready cycle.
- **ERR drain:** state ERR; push REG, INSTR, NULL → no strobes; `drop_count_o`=2.
- **Invalid op and saturation (`CNT_W`=8):** push 300 packets with op=7 → `drop_count_o`=255.
- **Back-to-back INSTR:** state IDLE, `net_valid_i` held with 4 INSTR packets → 4 consecutive `imem_we_o` cycles. Assert reset mid-stream → strobes 0 the next cycle and FIFO empty.

Source files
------------

// File: rtl/cl_net_cmd_unit_pkg.sv
// Shared types for the network command front end: core state, network
// opcode and the packed network packet.
package cl_net_cmd_unit_pkg;

  localparam int NET_ADDR_W = 10;
  localparam int NET_REG_W  = 6;
  localparam int NET_DATA_W = 32;

  // Core state as seen by the command gate.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_e;

  // Network opcode; encodings 5..7 are invalid and counted as drops.
  typedef enum logic [2:0] {
    OP_NULL  = 3'd0,
    OP_INSTR = 3'd1,
    OP_REG   = 3'd2,
    OP_PC    = 3'd3,
    OP_DMEM  = 3'd4
  } net_op_e;

  // 51-bit packet: op, addr, reg, data (MSB to LSB).
  typedef struct packed {
    net_op_e                 net_op;
    logic [NET_ADDR_W-1:0]   net_addr;
    logic [NET_REG_W-1:0]    net_reg;
    logic [NET_DATA_W-1:0]   net_data;
  } net_packet_s;

endpackage

// File: rtl/cl_net_cmd_unit_if.sv
// Network port: packet, valid and ready grouped as one handshake bundle.
interface cl_net_cmd_unit_if;
  import cl_net_cmd_unit_pkg::*;

  net_packet_s net_packet_i;
  logic        net_valid_i;
  logic        net_ready_o;

  // Packet source (network side).
  modport master (
    output net_packet_i,
    output net_valid_i,
    input  net_ready_o
  );

  // Packet sink (command unit side).
  modport slave (
    input  net_packet_i,
    input  net_valid_i,
    output net_ready_o
  );
endinterface

// File: rtl/cl_net_fifo.sv
// Small synchronous FIFO with registered storage. Pointers wrap modulo
// DEPTH; the occupancy count is one bit wider so full and empty are exact.
module cl_net_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next-state for pointers and occupancy.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Next-state for storage: write the tail slot on push.
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din_i;
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Packet storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; an empty count already marks every slot as invalid.
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cl_net_cmd_unit.sv
// Network command front end: buffers network packets and dispatches the
// FIFO head as one write strobe, gated by the current core state.
module cl_net_cmd_unit
  import cl_net_cmd_unit_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  cl_net_cmd_unit_if.slave      net_if,
  input  state_e                state_i,
  input  logic                  dmem_ready_i,
  output logic                  imem_we_o,
  output logic [NET_ADDR_W-1:0] imem_addr_o,
  output logic [NET_DATA_W-1:0] imem_data_o,
  output logic                  rf_we_o,
  output logic [NET_REG_W-1:0]  rf_addr_o,
  output logic [NET_DATA_W-1:0] rf_data_o,
  output logic                  dmem_we_o,
  output logic [NET_ADDR_W-1:0] dmem_addr_o,
  output logic [NET_DATA_W-1:0] dmem_data_o,
  output logic                  net_PC_write_cmd_IDLE_o,
  output logic [NET_ADDR_W-1:0] net_pc_o,
  output logic [CNT_W-1:0]      drop_count_o
);
  localparam int PKT_W = $bits(net_packet_s);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             fifo_full;
  logic             fifo_empty;
  logic             ready;
  logic             push;
  logic             pop;
  logic             drop;
  logic             head_vld;
  logic [PKT_W-1:0] head_bits;
  net_packet_s      head;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  // Ready depends only on the registered count, never on this cycle's pop.
  assign ready             = !fifo_full && !reset;
  assign net_if.net_ready_o = ready;
  assign push              = net_if.net_valid_i && ready;

  cl_net_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PKT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (net_if.net_packet_i),
    .head_o  (head_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head     = head_bits;
  assign head_vld = !fifo_empty && !reset;

  // Data outputs always follow the head; only the strobes qualify them.
  assign imem_addr_o = head.net_addr;
  assign imem_data_o = head.net_data;
  assign rf_addr_o   = head.net_reg;
  assign rf_data_o   = head.net_data;
  assign dmem_addr_o = head.net_addr;
  assign dmem_data_o = head.net_data;
  assign net_pc_o    = head.net_addr;

  // Decode the head against the core state: pick one strobe, pop, or drop.
  always_comb begin
    imem_we_o               = 1'b0;
    rf_we_o                 = 1'b0;
    dmem_we_o               = 1'b0;
    net_PC_write_cmd_IDLE_o = 1'b0;
    pop                     = 1'b0;
    drop                    = 1'b0;
    if (head_vld) begin
      if (state_i == ERR) begin
        // Drain one packet per cycle; only non-NULL packets count as drops.
        pop  = 1'b1;
        drop = (head.net_op != OP_NULL);
      end else begin
        case (head.net_op)
          OP_NULL: pop = 1'b1;
          OP_INSTR: begin
            imem_we_o = 1'b1;
            pop       = 1'b1;
          end
          OP_REG: begin
            // Outside IDLE the head stalls and blocks everything behind it.
            rf_we_o = (state_i == IDLE);
            pop     = (state_i == IDLE);
          end
          OP_PC: begin
            net_PC_write_cmd_IDLE_o = (state_i == IDLE);
            pop                     = (state_i == IDLE);
          end
          OP_DMEM: begin
            // Held with stable fields until the memory takes it.
            dmem_we_o = 1'b1;
            pop       = dmem_ready_i;
          end
          default: begin
            pop  = 1'b1;
            drop = 1'b1;
          end
        endcase
      end
    end
  end

  // Saturating drop counter: holds at all-ones instead of wrapping.
  always_comb begin
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != CNT_MAX)) drop_count_d = drop_count_q + CNT_ONE;
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (reset) drop_count_q <= '0;
    else       drop_count_q <= drop_count_d;
  end

  assign drop_count_o = drop_count_q;

endmodule
